// File: rtl/layer_output_buffer.sv
// Layer output buffer: collects P-lane accumulator beats into M quantized rows, then drains them in order.
// Define LAYER_OUT_SATURATE_EN to clamp to the output range instead of wrapping.
module layer_output_buffer #(
    parameter int M     = 16,
    parameter int P     = 1,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int FRAC  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_valid,
    input  logic [P*ACC_W-1:0]   acc_data,
    input  logic [P-1:0]         lane_en,
    input  logic                 act_sel,
    output logic                 acc_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_last
);

    localparam int WP_W = $clog2(M + P) + 1;
    localparam int RD_W = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t                 state;
    logic [WP_W-1:0]        wr_ptr;
    logic [RD_W-1:0]        rd_ptr;
    logic [OUT_W-1:0]       buf_q   [M];
    logic [OUT_W-1:0]       buf_nxt [M];
    logic [OUT_W-1:0]       lane_q  [P];
    logic [OUT_W-1:0]       rd_next_data;
    logic                   accept;

    function automatic logic [OUT_W-1:0] quantize(input logic signed [ACC_W-1:0] acc,
                                                  input logic relu);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC;
        if (relu && (sh < 0))
            sh = '0;
`ifdef LAYER_OUT_SATURATE_EN
        if (sh > $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}))
            return {1'b0, {(OUT_W-1){1'b1}}};
        if (sh < $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}))
            return {1'b1, {(OUT_W-1){1'b0}}};
        return sh[OUT_W-1:0];
`else
        return sh[OUT_W-1:0];
`endif
    endfunction

    assign acc_ready = (state == S_FILL);
    assign accept    = acc_valid && (state == S_FILL);

    // Quantize every lane, then scatter enabled in-range lanes into the row buffer.
    always_comb begin
        for (int i = 0; i < P; i++)
            lane_q[i] = quantize(acc_data[i*ACC_W +: ACC_W], act_sel);
        for (int r = 0; r < M; r++) begin
            buf_nxt[r] = buf_q[r];
            for (int i = 0; i < P; i++) begin
                if (accept && lane_en[i] && (wr_ptr + WP_W'(i) == WP_W'(r)))
                    buf_nxt[r] = lane_q[i];
            end
        end
    end

    always_comb begin
        rd_next_data = '0;
        for (int r = 0; r < M; r++) begin
            if (rd_ptr + RD_W'(1) == RD_W'(r))
                rd_next_data = buf_q[r];
        end
    end

    // The first drained row comes from buf_nxt so the final beat's lanes are visible one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            buf_q     <= '{default: '0};
        end else begin
            buf_q <= buf_nxt;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (wr_ptr + WP_W'(P) >= WP_W'(M)) begin
                            state     <= S_DRAIN;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            out_valid <= 1'b1;
                            out_data  <= buf_nxt[0];
                            out_last  <= (M == 1);
                        end else begin
                            wr_ptr <= wr_ptr + WP_W'(P);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (rd_ptr == RD_W'(M - 1)) begin
                            state     <= S_FILL;
                            rd_ptr    <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_ptr   <= rd_ptr + RD_W'(1);
                            out_data <= rd_next_data;
                            out_last <= (rd_ptr + RD_W'(1) == RD_W'(M - 1));
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: doc/layer_output_buffer.md
LAYER_OUTPUT_BUFFER -- requirements
Module: layer_output_buffer

Interface
REQ-001 Parameter M, default 16: number of output rows per layer pass.
REQ-002 Parameter P, default 1: accumulator lanes per beat. M is a multiple of P.
REQ-003 Parameter ACC_W, default 32: signed accumulator width per lane.
REQ-004 Parameter OUT_W, default 16: signed output element width.
REQ-005 Parameter FRAC, default 8: arithmetic right-shift applied to each accumulator value.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 acc_valid  input  1  accumulator results present on acc_data.
REQ-009 acc_data  input  P*ACC_W  lane i occupies bits [i*ACC_W +: ACC_W].
REQ-010 lane_en  input  P  lane i result is a real row; driven from the controller's f_sel.
REQ-011 act_sel  input  1  1 = ReLU, 0 = identity; sampled per beat.
REQ-012 acc_ready  output  1  block accepts a beat.
REQ-013 out_valid  output  1  out_data holds a valid element.
REQ-014 out_ready  input  1  downstream accepts the element.
REQ-015 out_data  output  OUT_W  quantized, activated element.
REQ-016 out_last  output  1  high with element M-1.

Function
REQ-017 The block SHALL implement two states: S_FILL (acc_ready=1, out_valid=0) and S_DRAIN (acc_ready=0).
REQ-018 A beat is accepted when acc_valid && acc_ready.
REQ-019 On acceptance, lane i SHALL be written to buffer[wr_ptr+i] when lane_en[i]=1 and wr_ptr+i<M; other lanes are discarded. wr_ptr SHALL advance by P.
REQ-020 Processing per lane SHALL be: signed arithmetic shift right by FRAC, then ReLU if act_sel (negative -> 0), then width reduction per REQ-030.
REQ-021 When the accepted beat brings wr_ptr+P>=M, the state SHALL move to S_DRAIN on the next edge, and wr_ptr SHALL reset to 0.
REQ-022 The first out_valid SHALL appear in the cycle after the final accepted beat; latency is one cycle.
REQ-023 S_DRAIN SHALL present buffer[0..M-1] in order, advancing rd_ptr only on out_valid && out_ready.
REQ-024 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-025 Outputs SHALL be registered, with no combinational path from out_ready to out_data.
REQ-026 After the handshake of element M-1, out_valid SHALL drop and the state SHALL return to S_FILL on the same edge. rd_ptr SHALL return to 0.
REQ-027 acc_valid in S_DRAIN SHALL be ignored, with no buffer write.
REQ-028 A row whose lane was disabled SHALL retain its previous buffer value.

Reset
REQ-029 Reset SHALL force the following, with no stale handshake after release:
- state = S_FILL, wr_ptr = 0, rd_ptr = 0
- out_valid = 0, out_data = 0, out_last = 0
- all buffer entries = 0
- acc_ready = 1

Configuration
REQ-030 With macro LAYER_OUT_SATURATE_EN defined, the shifted value SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Without the macro, the low OUT_W bits SHALL be taken (wrap).

Verification (M=4, P=1, FRAC=8, OUT_W=16, ACC_W=32)
REQ-031 Four beats of acc_data 0x00000300, act_sel=1, out_ready=1 -> four elements of out_data=0x0003. out_last is high only on the 4th element. First out_valid occurs one cycle after the 4th beat.
REQ-032 acc_data 0xFFFFFE00 -> with act_sel=1, out_data=0x0000; with act_sel=0, out_data=0xFFFE.
REQ-033 acc_data 0x7FFFFFFF -> out_data=0x7FFF with LAYER_OUT_SATURATE_EN defined; out_data=0xFFFF without it.
REQ-034 Backpressure: out_ready low for 3 cycles at element 1 -> out_data stable, no element skipped or duplicated, sequence 0..3 intact.
REQ-035 acc_valid=1 with 0x12345600 during S_DRAIN -> acc_ready=0, drained values unchanged, next pass unaffected.
REQ-036 Reset pulsed after element 1 handshake -> out_valid=0 next cycle, acc_ready=1; a fresh 4-beat pass then drains correctly from element 0.
